// File: rtl/sample_capture.sv
// Triggered frame capture: waits for an edge/free-run trigger, fills a SAMPLES-deep bank,
// then publishes the whole bank to a registered parallel array with a one-cycle frame_valid.
module sample_capture #(
  parameter int SAMPLES = 80,
  parameter int WIDTH   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] trig_level,
  input  logic [1:0]       trig_mode,
  input  logic             arm,
  input  logic             continuous,
  input  logic             abort,
  output logic [WIDTH-1:0] data [SAMPLES-1:0],
  output logic             frame_valid,
  output logic             busy,
  output logic [15:0]      frame_count
);

  localparam int IW = $clog2(SAMPLES);
  localparam logic [IW-1:0] LAST = IW'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, PUBLISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cap_buf [SAMPLES-1:0];
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] prev;
  logic             prev_ok;
  logic             trig;
  logic             buf_we;
  logic [IW-1:0]    buf_idx;
  logic             pub;

  always_comb begin
    state_nxt = state;
    buf_we    = 1'b0;
    buf_idx   = wr_idx;
    pub       = 1'b0;
    if (trig_mode[1])
      trig = 1'b1;
    else if (trig_mode[0])
      trig = prev_ok && (prev >= trig_level) && (sample_in < trig_level);
    else
      trig = prev_ok && (prev < trig_level) && (sample_in >= trig_level);

    // abort outranks every other transition, including the publish itself
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm) state_nxt = ARMED;
        ARMED: begin
          if (sample_valid && trig) begin
            buf_we    = 1'b1;
            buf_idx   = '0;
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            buf_we = 1'b1;
            if (wr_idx == LAST) state_nxt = PUBLISH;
          end
        end
        PUBLISH: begin
          pub       = 1'b1;
          state_nxt = continuous ? ARMED : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The bank has no reset; its contents only matter once a full frame is written.
  always_ff @(posedge clk) begin
    if (buf_we) cap_buf[buf_idx] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      wr_idx      <= '0;
      prev        <= '0;
      prev_ok     <= 1'b0;
      for (int i = 0; i < SAMPLES; i++) data[i] <= '0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      frame_valid <= pub;
      if (pub) begin
        data        <= cap_buf;
        frame_count <= frame_count + 16'd1;
      end
      if (!abort) begin
        case (state)
          IDLE:    if (arm) prev_ok <= 1'b0;
          ARMED: begin
            if (sample_valid) begin
              prev    <= sample_in;
              prev_ok <= 1'b1;
              if (trig) wr_idx <= IW'(1);
            end
          end
          CAPTURE: if (sample_valid) wr_idx <= wr_idx + 1'b1;
          PUBLISH: begin
            // edge triggers need two fresh samples after a re-arm
            prev_ok <= 1'b0;
            wr_idx  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: expected frame samples are queued as stimulus is driven
// and compared against the published array whenever frame_valid strobes.
module tb_sample_capture;

  localparam int SAMPLES = 80;
  localparam int WIDTH   = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] trig_level = '0;
  logic [1:0]       trig_mode = 2'b00;
  logic             arm = 1'b0;
  logic             continuous = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] data [SAMPLES-1:0];
  logic             frame_valid;
  logic             busy;
  logic [15:0]      frame_count;

  int errors = 0;
  int checks = 0;
  int fv_seen = 0;
  logic [WIDTH-1:0] exp_q [$];

  sample_capture #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_level(trig_level), .trig_mode(trig_mode), .arm(arm), .continuous(continuous),
    .abort(abort), .data(data), .frame_valid(frame_valid), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every published frame must match the next SAMPLES queued samples.
  always @(posedge clk) begin
    int bad;
    logic [WIDTH-1:0] e, bv, be;
    #1;
    if (frame_valid === 1'b1) begin
      fv_seen++;
      checks++;
      if (exp_q.size() < SAMPLES) begin
        errors++;
        $display("FAIL frame_unexpected: frame_valid with %0d samples queued, required %0d",
                 exp_q.size(), SAMPLES);
        exp_q.delete();
      end else begin
        bad = -1;
        bv = '0;
        be = '0;
        for (int i = 0; i < SAMPLES; i++) begin
          e = exp_q.pop_front();
          if (data[i] !== e && bad < 0) begin
            bad = i;
            bv  = data[i];
            be  = e;
          end
        end
        if (bad >= 0) begin
          errors++;
          $display("FAIL frame_data: data[%0d]=%h, required %h", bad, bv, be);
        end
      end
      checks++;
      if (frame_count !== 16'(fv_seen)) begin
        errors++;
        $display("FAIL frame_count_at_strobe: got %0d, required %0d", frame_count, fv_seen);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b fv=%b fc=%0d, required 0 0 0", busy, frame_valid, frame_count);
    end
    checks++;
    if (data[0] !== 12'h000 || data[SAMPLES-1] !== 12'h000) begin
      errors++;
      $display("FAIL reset_data: data[0]=%h data[79]=%h, required 000 000", data[0], data[SAMPLES-1]);
    end
  endtask

  task automatic test_rising();
    trig_mode  = 2'b00;
    trig_level = 12'h800;
    continuous = 1'b0;
    do_arm();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL arm_busy: busy=%b, required 1", busy);
    end
    send(12'h7F0);
    send(12'h7F8);
    for (int i = 0; i < SAMPLES; i++) begin
      exp_q.push_back(12'(12'h800 + 8 * i));
      send(12'(12'h800 + 8 * i));
    end
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rise_last_edge: fv=%b busy=%b, required 0 1", frame_valid, busy);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rise_publish: fv=%b fc=%0d busy=%b, required 1 1 0", frame_valid, frame_count, busy);
    end
    checks++;
    if (data[0] !== 12'h800 || data[SAMPLES-1] !== 12'hA78) begin
      errors++;
      $display("FAIL rise_data: data[0]=%h data[79]=%h, required 800 a78", data[0], data[SAMPLES-1]);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rise_strobe_drop: fv=%b busy=%b, required 0 0", frame_valid, busy);
    end
  endtask

  task automatic test_falling_gaps();
    trig_mode  = 2'b01;
    trig_level = 12'h800;
    do_arm();
    send(12'h900);
    send(12'h900);
    exp_q.push_back(12'h7FF);
    send(12'h7FF);
    for (int i = 0; i < SAMPLES - 1; i++) begin
      exp_q.push_back(12'(12'h100 + i));
      send(12'(12'h100 + i));
      sample_in = 12'hFFF;
      tick();
      tick();
    end
    // last sample went in three edges ago; publish already happened two ticks back
    checks++;
    if (frame_count !== 16'd2 || data[0] !== 12'h7FF || data[SAMPLES-1] !== 12'h14E) begin
      errors++;
      $display("FAIL fall_gaps: fc=%0d data[0]=%h data[79]=%h, required 2 7ff 14e",
               frame_count, data[0], data[SAMPLES-1]);
    end
    checks++;
    if (busy !== 1'b0 || fv_seen !== 2) begin
      errors++;
      $display("FAIL fall_gaps_ctrl: busy=%b frames=%0d, required 0 2", busy, fv_seen);
    end
  endtask

  task automatic test_continuous();
    trig_mode  = 2'b10;
    continuous = 1'b1;
    do_arm();
    for (int v = 0; v <= 160; v++) begin
      if (v != 80) exp_q.push_back(12'(v));
      send(12'(v));
      if (v == 80) begin
        checks++;
        if (frame_valid !== 1'b1 || busy !== 1'b1 || data[0] !== 12'd0 || data[SAMPLES-1] !== 12'd79) begin
          errors++;
          $display("FAIL cont_frame1: fv=%b busy=%b data[0]=%0d data[79]=%0d, required 1 1 0 79",
                   frame_valid, busy, data[0], data[SAMPLES-1]);
        end
      end
    end
    continuous = 1'b0;
    tick();
    checks++;
    if (frame_valid !== 1'b1 || busy !== 1'b0 || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL cont_frame2: fv=%b busy=%b fc=%0d, required 1 0 4", frame_valid, busy, frame_count);
    end
    checks++;
    if (data[0] !== 12'd81 || data[SAMPLES-1] !== 12'd160) begin
      errors++;
      $display("FAIL cont_frame2_data: data[0]=%0d data[79]=%0d, required 81 160", data[0], data[SAMPLES-1]);
    end
    tick();
  endtask

  task automatic test_abort();
    trig_mode = 2'b10;
    do_arm();
    for (int i = 0; i < 40; i++) send(12'(12'h200 + i));
    abort = 1'b1;
    send(12'hABC);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_count !== 16'd4 || data[0] !== 12'd81) begin
      errors++;
      $display("FAIL abort_mid: busy=%b fv=%b fc=%0d data[0]=%0d, required 0 0 4 81",
               busy, frame_valid, frame_count, data[0]);
    end
    do_arm();
    for (int i = 0; i < SAMPLES; i++) send(12'(12'h500 + i));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_count !== 16'd4) begin
      errors++;
      $display("FAIL abort_publish: busy=%b fv=%b fc=%0d, required 0 0 4", busy, frame_valid, frame_count);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || data[0] !== 12'd81 || data[SAMPLES-1] !== 12'd160) begin
      errors++;
      $display("FAIL abort_hold: fv=%b data[0]=%0d data[79]=%0d, required 0 81 160",
               frame_valid, data[0], data[SAMPLES-1]);
    end
  endtask

  task automatic test_rst_mid();
    trig_mode = 2'b10;
    do_arm();
    for (int i = 0; i < 30; i++) send(12'(12'h600 + i));
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (frame_count !== 16'd0 || data[0] !== 12'd0 || data[SAMPLES-1] !== 12'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: fc=%0d data[0]=%h data[79]=%h busy=%b, required 0 000 000 0",
               frame_count, data[0], data[SAMPLES-1], busy);
    end
    fv_seen = 0;
    tick();
    rst = 1'b1;
    send(12'h111);
    send(12'h222);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_stays_idle: busy=%b, required 0", busy);
    end
    do_arm();
    for (int i = 0; i < SAMPLES; i++) begin
      exp_q.push_back(12'(12'h300 + i));
      send(12'(12'h300 + i));
    end
    tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_count !== 16'd1 || data[0] !== 12'h300 || data[SAMPLES-1] !== 12'h34F) begin
      errors++;
      $display("FAIL rst_fresh_frame: fv=%b fc=%0d data[0]=%h data[79]=%h, required 1 1 300 34f",
               frame_valid, frame_count, data[0], data[SAMPLES-1]);
    end
    tick();
  endtask

  task automatic test_level_above();
    trig_mode  = 2'b00;
    trig_level = 12'h800;
    do_arm();
    send(12'h900);
    send(12'h950);
    send(12'h820);
    send(12'h700);
    exp_q.push_back(12'h810);
    send(12'h810);
    for (int i = 0; i < SAMPLES - 1; i++) begin
      exp_q.push_back(12'(12'h400 + i));
      send(12'(12'h400 + i));
    end
    tick();
    checks++;
    if (frame_valid !== 1'b1 || frame_count !== 16'd2 || data[0] !== 12'h810 || data[1] !== 12'h400) begin
      errors++;
      $display("FAIL level_above: fv=%b fc=%0d data[0]=%h data[1]=%h, required 1 2 810 400",
               frame_valid, frame_count, data[0], data[1]);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling_gaps();
    test_continuous();
    test_abort();
    test_rst_mid();
    test_level_above();
    tick();
    checks++;
    if (exp_q.size() != 0 || fv_seen != 2) begin
      errors++;
      $display("FAIL scoreboard_drain: queued=%0d frames=%0d, required 0 2", exp_q.size(), fv_seen);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Acquisition stage ahead of the waveform statistics block. It takes a stream of 12-bit ADC samples and waits for a trigger condition. It then captures a frame of `SAMPLES` consecutive samples into an internal bank and publishes the completed frame as a stable parallel array. The array, together with a one-cycle `frame_valid` strobe, drives the average/min/max computation and the display path.

## Interface
- `SAMPLES`, 80: samples per frame; the index counter is sized `$clog2(SAMPLES)` bits.
- `WIDTH`, 12: sample width in bits.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock, no other resets.
- `sample_in`  in  WIDTH  ADC sample; meaningful only when `sample_valid` = 1.
- `sample_valid`  in  1  one-cycle qualifier per new sample.
- `trig_level`  in  WIDTH  trigger threshold, unsigned.
- `trig_mode`  in  2  00 rising edge, 01 falling edge, 10 free-run, 11 treated as 10.
- `arm`  in  1  pulse that starts an acquisition from IDLE.
- `continuous`  in  1  1 = re-arm automatically after each publish.
- `abort`  in  1  pulse that returns to IDLE without publishing.
- `data`  out  WIDTH x SAMPLES  published frame, unpacked `[SAMPLES-1:0]`; index 0 is the trigger sample.
- `frame_valid`  out  1  one-cycle strobe: `data` was just updated.
- `busy`  out  1  high in ARMED, CAPTURE and PUBLISH.
- `frame_count`  out  16  number of frames published, wraps at 2^16.

## Operation
- States: IDLE, ARMED, CAPTURE, PUBLISH. Internal signals: capture bank `buf[SAMPLES]`, write index `wr_idx`, previous-sample register `prev` with flag `prev_ok`.
- **IDLE**
  - `arm` = 1 → ARMED; `prev_ok` <= 0.
  - `sample_valid` is ignored.
- **ARMED** (acts on each cycle with `sample_valid` = 1)
  - `prev` <= `sample_in`, `prev_ok` <= 1.
  - Trigger fires when any of these holds:
    - rising mode: `prev_ok` && `prev` < `trig_level` && `sample_in` >= `trig_level`.
    - falling mode: `prev_ok` && `prev` >= `trig_level` && `sample_in` < `trig_level`.
    - free-run: always.
  - On trigger: `buf[0]` <= `sample_in`, `wr_idx` <= 1, → CAPTURE.
- **CAPTURE** (acts on each valid sample)
  - `buf[wr_idx]` <= `sample_in`, `wr_idx` += 1.
  - When the sample written is at `wr_idx` = SAMPLES-1 → PUBLISH.
  - No trigger evaluation in this state.
- **PUBLISH** (exactly one cycle)
  - `data` <= `buf` (whole array in one edge), `frame_valid` <= 1, `frame_count` += 1.
  - Next state: ARMED with `prev_ok` <= 0 if `continuous` = 1, else IDLE.
  - Samples presented during PUBLISH are dropped.
- `data` holds its value between publishes, so downstream combinational logic sees a frame that stays stable until the next `frame_valid`.
- **`abort`**
  - From any state → IDLE on the next edge. `data`, `frame_count` and `buf` are unchanged; no `frame_valid`.
  - `abort` has priority over `arm`, over trigger, and over the PUBLISH transfer: `abort` asserted in the PUBLISH cycle suppresses the publish.
- `arm` outside IDLE is ignored.
- `trig_level` and `trig_mode` are sampled live every cycle; software changes them only in IDLE.
- Comparisons are unsigned WIDTH-bit. There is no hysteresis.

## Timing
- Reset values: state IDLE, `data` all 0, `frame_valid` 0, `busy` 0, `frame_count` 0, `wr_idx` 0, `prev_ok` 0. `buf` contents are don't-care.
- `rst` asserted mid-capture clears everything immediately (asynchronously). After deassertion the block stays in IDLE until `arm`.
- `arm` at edge E → `busy` = 1 after E.
- Trigger sample accepted at edge T. The last sample (index SAMPLES-1) is accepted at the edge where SAMPLES valid samples have been taken since T (T counted).
  - With one valid sample every cycle, that edge is T+SAMPLES-1.
- PUBLISH occupies the cycle after the last-sample edge L. `data`, `frame_valid` = 1 and the new `frame_count` are visible after L+1. `frame_valid` drops after L+2.
- `busy` falls after L+1 unless `continuous` = 1.
- Continuous, edge trigger: at least two valid samples after L+1 are needed before the next trigger, because `prev_ok` restarts at 0.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Test plan
- Rising trigger: `trig_level` = 0x800, ramp 0x7F0, 0x7F8, 0x800, 0x808… one sample per cycle → `data[0]` = 0x800, `data[79]` = 0x800 + 79·8, one `frame_valid` pulse, `frame_count` = 1.
- Falling trigger with gaps: samples 0x900, 0x900, 0x7FF, then one valid sample every third cycle → `data[0]` = 0x7FF, 80 samples captured in order, gap cycles not stored.
- Free-run with `continuous` = 1: counter data 0,1,2,… → frame 1 is `data[i]` = i; the sample arriving in the PUBLISH cycle (value 80) is dropped, so frame 2 starts at 81; `frame_count` = 2.
- Abort at `wr_idx` = 40, then again in the PUBLISH cycle → no `frame_valid`, `data` keeps the previous frame, `busy` = 0 the next cycle.
- `rst` pulled low mid-CAPTURE → `data` = 0 and `frame_count` = 0 immediately; a later `arm` captures a full fresh frame.
- Level already above threshold at arm (first sample 0x900, level 0x800, rising mode) → no trigger until the signal goes below the level and crosses back up.
